spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  Single-byte SPI master (mode 0: CPOL=0, CPHA=0, MSB first), the initiator for SPISlave.
//  Runs on clk_system and generates sclk, mosi and slave_select_n.
//  Used by the flight controller to talk to SPI sensors and to drive SPISlave in loopback.
//  Each start exchanges one word: wr_data is shifted out while the miso word is captured.
// PARAMETERS
//  DATA_WIDTH  8  bits per transfer (>=2)
//  CLK_DIV     4  clk_system cycles per sclk half-period (>=2)
//  SS_SETUP    2  clk_system cycles from ss low to the first sclk half-period start (>=1)
//  SS_HOLD     2  clk_system cycles from the last sclk fall to ss high (>=1)
// PORTS
//  clk_system      in   1           system clock (20 MHz); all logic on its rising edge
//  reset           in   1           synchronous, active-high reset
//  start           in   1           request a transfer; sampled only while busy=0
//  wr_data         in   DATA_WIDTH  word to transmit; captured on an accepted start
//  miso            in   1           serial data from the slave
//  sclk            out  1           SPI clock; idles low
//  mosi            out  1           serial data to the slave
//  slave_select_n  out  1           active-low chip select
//  rd_data         out  DATA_WIDTH  last received word; holds until the next done
//  busy            out  1           high from accept until the done cycle (exclusive)
//  done            out  1           one-cycle pulse when a transfer completes
// BEHAVIOUR
//  Outputs: all outputs are registered.
//  Reset values: sclk=0, mosi=0, slave_select_n=1, busy=0, done=0, rd_data=0, state=IDLE.
//  Reset mid-transfer: abort at the next edge and apply the reset values. No done pulse.
//  States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
//  IDLE:
//   - start=1 at edge E0 latches wr_data into the tx shift register.
//   - At E0+1: state=SETUP, slave_select_n=0, busy=1, mosi=wr_data[MSB].
//  SETUP:
//   - Count SS_SETUP cycles, then go to XFER.
//  XFER:
//   - A half-period counter toggles sclk every CLK_DIV cycles.
//   - Produces exactly DATA_WIDTH rising and DATA_WIDTH falling edges.
//   - Rise (sclk 0->1 edge): shift miso into the rx register, LSB in, MSB-first order.
//   - Fall (sclk 1->0 edge), except the last: mosi takes the next lower tx bit.
//   - Last fall: mosi -> 0; enter HOLD.
//  HOLD:
//   - sclk stays 0.
//   - After SS_HOLD cycles, in the same edge: slave_select_n=1, busy=0, done=1, rd_data=rx register.
//   - Then return to IDLE.
//  Latency: done at E0 + 1 + SS_SETUP + 2*DATA_WIDTH*CLK_DIV + SS_HOLD.
//   - Defaults: E0+69.
//   - sclk first rises at E0+1+SS_SETUP+CLK_DIV (E0+7 with defaults).
//  start while busy=1: ignored. wr_data is not re-sampled during the transfer.
//  start=1 in the done cycle:
//   - Accepted, since busy=0 then.
//   - slave_select_n stays high exactly 1 cycle before the next transfer.
//  done=1 for exactly one cycle per completed transfer.
//  rd_data changes only in done cycles (or on reset).
//  Timing: mosi changes only on sclk falls or at SETUP entry, so it is stable across every rise.
//  sclk never toggles while slave_select_n=1.
// TESTING
//  1. Reset, then start with wr_data=8'hAA; a slave model returns 8'hB7.
//     -> mosi bits at rises: 1,0,1,0,1,0,1,0.
//     -> rd_data=8'hB7 and done pulse at E0+69.
//     -> exactly 8 sclk rises.
//  2. Loopback with miso tied to mosi, wr_data=8'h3C -> rd_data=8'h3C; busy high cycles E0+1..E0+68.
//  3. Pulse start again at E0+20 with wr_data=8'hFF -> ignored; rd_data still the first word; one done only.
//  4. Back-to-back: start held high, wr_data 8'h01 then 8'h80.
//     -> two done pulses 69 cycles apart.
//     -> slave_select_n high for 1 cycle between transfers.
//  5. Reset asserted at E0+30 (mid-XFER).
//     -> next edge: sclk=0, slave_select_n=1, busy=0.
//     -> no done pulse; rd_data=0.
//  6. CLK_DIV=2, SS_SETUP=1, SS_HOLD=1, wr_data=8'h5A with loopback.
//     -> done at E0+35, rd_data=8'h5A.

Source files
------------

// File: rtl/spi_master.sv
// Single-word SPI mode-0 master, MSB first; done arrives 1+SS_SETUP+2*DATA_WIDTH*CLK_DIV+SS_HOLD cycles after start.
// Start is honoured only while idle; requests made during a transfer are dropped.
module spi_master #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 4,
   parameter int SS_SETUP   = 2,
   parameter int SS_HOLD    = 2
) (
   input  logic                  clk_system,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  miso,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  slave_select_n,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done
);

   localparam int CMAX = (CLK_DIV > SS_SETUP) ? ((CLK_DIV > SS_HOLD) ? CLK_DIV : SS_HOLD)
                                              : ((SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD);
   localparam int CW = $clog2(CMAX + 1);
   localparam int BW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic                  ss_n_q, ss_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   always_ff @(posedge clk_system) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rd_data_q <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         ss_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ss_n_q    <= ss_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ss_n_d    = ss_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
               ss_n_d  = 1'b0;
               busy_d  = 1'b1;
               tx_d    = wr_data;
               mosi_d  = wr_data[DATA_WIDTH-1];
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         SETUP: begin
            if (cnt_q == CW'(SS_SETUP - 1)) begin
               state_d = XFER;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         XFER: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  rx_d = {rx_q[DATA_WIDTH-2:0], miso};
               end else if (bit_q == BW'(DATA_WIDTH - 1)) begin
                  mosi_d  = 1'b0;
                  state_d = HOLD;
               end else begin
                  // Rotate rather than shift so the register never carries dead bits.
                  mosi_d = tx_q[DATA_WIDTH-2];
                  tx_d   = {tx_q[DATA_WIDTH-2:0], tx_q[DATA_WIDTH-1]};
                  bit_d  = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            if (cnt_q == CW'(SS_HOLD - 1)) begin
               state_d   = IDLE;
               cnt_d     = '0;
               ss_n_d    = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rd_data_d = rx_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sclk           = sclk_q;
   assign mosi           = mosi_q;
   assign slave_select_n = ss_n_q;
   assign rd_data        = rd_data_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule
